dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// default geometry and the request record captured at acceptance.
package dmem_pkg;

   localparam int LATENCY_DEF = 4;
   localparam int DEPTH_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port 2^DEPTH_W x 16 storage: synchronous write, combinational read.
module dmem_array #(
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               we,
   input  logic [DEPTH_W-1:0] addr,
   input  logic [15:0]        wdata,
   output logic [15:0]        rdata
);

   // Zero at time zero only; reset never clears the contents.
   logic [15:0] mem [0:(1<<DEPTH_W)-1] = '{default: 16'h0000};

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder: accepts one request in IDLE, waits
// LATENCY cycles, then pulses a one-cycle response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEF,
   parameter int DEPTH_W = DEPTH_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err
);

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   req_t               req_q;
   logic               accept;
   logic               misaligned;
   logic               mem_we;
   logic [DEPTH_W-1:0] word_idx;
   logic [15:0]        mem_rdata;
   logic               unused_addr_bits;

   assign accept     = req_valid && (state_q == IDLE);
   assign misaligned = req_q.addr[0];
   assign word_idx   = req_q.addr[DEPTH_W:1];

   // Upper address bits are deliberately dropped so addresses wrap.
   assign unused_addr_bits = ^req_q.addr[15:DEPTH_W+1];

   // State, countdown and request capture; the request is held untouched
   // until the FSM is back in IDLE so input wiggles cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            req_q <= '{wr: req_wr, addr: req_addr, wdata: req_wdata};
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = WAIT;
               cnt_d   = 4'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // A store commits on the edge that enters RESP; reset on that same edge
   // abandons it, as does a misaligned address.
   always_comb begin
      mem_we = 1'b0;
      if ((state_q == WAIT) && (cnt_q == 4'd0) && req_q.wr && !misaligned && !rst) begin
         mem_we = 1'b1;
      end
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      resp_valid = 1'b0;
      resp_rdata = 16'h0000;
      resp_err   = 1'b0;
      if (state_q == RESP) begin
         resp_valid = 1'b1;
         resp_err   = misaligned;
         if (!req_q.wr && !misaligned) begin
            resp_rdata = mem_rdata;
         end
      end
   end

   dmem_array #(
      .DEPTH_W(DEPTH_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (word_idx),
      .wdata (req_q.wdata),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=4, DEPTH_W=10; each task
// drives one scenario and checks hand-computed results inline.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;

   int vectors;
   int miscompares;

   dmem_responder #(
      .LATENCY(4),
      .DEPTH_W(10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Presents one request from an IDLE cycle (caller sits 1 time unit after
   // an edge), then reports edges-to-response, readiness after acceptance,
   // response data and whether resp_valid lingered past one cycle.
   task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat, output logic rdy_after,
                        output logic [15:0] rdata, output logic err, output logic pulse_after);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid   = 1'b0;
      rdy_after   = req_ready;
      lat         = -1;
      rdata       = 16'hxxxx;
      err         = 1'bx;
      pulse_after = 1'bx;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin
            lat   = i;
            rdata = resp_rdata;
            err   = resp_err;
            break;
         end
      end
      @(posedge clk); #1;
      pulse_after = resp_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
      end
      vectors++;
      if ({resp_valid, resp_err, resp_rdata} !== 18'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b err=%b rdata=%h want 0/0/0000",
                  resp_valid, resp_err, resp_rdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      int lat; logic rdy, err, pa; logic [15:0] rd;
      issue(1'b1, 16'h0016, 16'hBEEF, lat, rdy, rd, err, pa);
      vectors++;
      if (rdy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL st_ready_drop: got %b want 0", rdy);
      end
      vectors++;
      if (lat !== 4) begin
         miscompares++; $display("[TB] FAIL st_latency: got %0d want 4", lat);
      end
      vectors++;
      if ({err, rd} !== 17'h0) begin
         miscompares++; $display("[TB] FAIL st_resp: got err=%b rdata=%h want 0/0000", err, rd);
      end
      vectors++;
      if (pa !== 1'b0) begin
         miscompares++; $display("[TB] FAIL st_one_cycle: got %b want 0", pa);
      end
      issue(1'b0, 16'h0016, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if (rdy !== 1'b0) begin
         miscompares++; $display("[TB] FAIL ld_ready_drop: got %b want 0", rdy);
      end
      vectors++;
      if (lat !== 4) begin
         miscompares++; $display("[TB] FAIL ld_latency: got %0d want 4", lat);
      end
      vectors++;
      if ({err, rd} !== {1'b0, 16'hBEEF}) begin
         miscompares++; $display("[TB] FAIL ld_data: got err=%b rdata=%h want 0/beef", err, rd);
      end
   endtask

   task automatic test_misaligned();
      int lat; logic rdy, err, pa; logic [15:0] rd;
      issue(1'b0, 16'h0017, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if ({lat == 4, err, rd} !== {1'b1, 1'b1, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL mis_load: got lat=%0d err=%b rdata=%h want 4/1/0000", lat, err, rd);
      end
      issue(1'b1, 16'h0017, 16'h1234, lat, rdy, rd, err, pa);
      vectors++;
      if ({lat == 4, err, rd} !== {1'b1, 1'b1, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL mis_store: got lat=%0d err=%b rdata=%h want 4/1/0000", lat, err, rd);
      end
      issue(1'b0, 16'h0016, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if ({err, rd} !== {1'b0, 16'hBEEF}) begin
         miscompares++; $display("[TB] FAIL mis_no_write: got err=%b rdata=%h want 0/beef", err, rd);
      end
   endtask

   task automatic test_wrap();
      int lat; logic rdy, err, pa; logic [15:0] rd;
      issue(1'b1, 16'h0800, 16'hA5A5, lat, rdy, rd, err, pa);
      issue(1'b0, 16'h0000, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if ({err, rd} !== {1'b0, 16'hA5A5}) begin
         miscompares++; $display("[TB] FAIL wrap_load: got err=%b rdata=%h want 0/a5a5", err, rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat, lat2; logic rdy, err, pa; logic [15:0] rd;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0016; req_wdata = 16'h0000;
      @(posedge clk); #1;
      // Keep req_valid high and morph the request while the load is pending.
      req_wr = 1'b1; req_addr = 16'h0040; req_wdata = 16'h5555;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin
            lat = i; rd = resp_rdata; err = resp_err;
            break;
         end
         req_wdata = req_wdata + 16'h0001;
         req_wdata = 16'h5555;
      end
      vectors++;
      if ({lat == 4, err, rd} !== {1'b1, 1'b0, 16'hBEEF}) begin
         miscompares++; $display("[TB] FAIL hold_first: got lat=%0d err=%b rdata=%h want 4/0/beef", lat, err, rd);
      end
      @(posedge clk); #1;
      vectors++;
      if ({req_ready, resp_valid} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL hold_idle: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++; $display("[TB] FAIL hold_second_accept: got ready=%b want 0", req_ready);
      end
      lat2 = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) begin
            lat2 = i; rd = resp_rdata; err = resp_err;
            break;
         end
      end
      vectors++;
      if ({lat2 == 4, err, rd} !== {1'b1, 1'b0, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL hold_second: got lat=%0d err=%b rdata=%h want 4/0/0000", lat2, err, rd);
      end
      @(posedge clk); #1;
      issue(1'b0, 16'h0040, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if (rd !== 16'h5555) begin
         miscompares++; $display("[TB] FAIL hold_second_data: got %h want 5555", rd);
      end
   endtask

   task automatic test_reset_mid();
      int lat, seen; logic rdy, err, pa; logic [15:0] rd;
      // Reset two cycles after acceptance, while WAIT is counting.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h00FF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++; $display("[TB] FAIL rst_wait_noresp: got %0d pulses want 0", seen);
      end
      issue(1'b0, 16'h0020, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if ({lat == 4, rd} !== {1'b1, 16'h0000}) begin
         miscompares++; $display("[TB] FAIL rst_wait_nowrite: got lat=%0d rdata=%h want 4/0000", lat, rd);
      end
      // Reset landing exactly on the edge that would enter RESP.
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h7777;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if ({req_ready, resp_valid} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL rst_resp_entry: got ready=%b valid=%b want 1/0", req_ready, resp_valid);
      end
      issue(1'b0, 16'h0030, 16'h0000, lat, rdy, rd, err, pa);
      vectors++;
      if (rd !== 16'h0000) begin
         miscompares++; $display("[TB] FAIL rst_resp_nowrite: got %h want 0000", rd);
      end
   endtask

   task automatic test_reset_accept();
      int seen;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0016; req_wdata = 16'h0000;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("[TB] FAIL rst_accept_ready: got %b want 1", req_ready);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp_valid === 1'b1) seen++;
      end
      vectors++;
      if (seen !== 0) begin
         miscompares++; $display("[TB] FAIL rst_accept_noresp: got %0d pulses want 0", seen);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_wr      = 1'b0;
      req_addr    = 16'h0000;
      req_wdata   = 16'h0000;
      test_reset();
      test_store_load();
      test_misaligned();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_reset_accept();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
